// File: rtl/register_pkg.sv
// Shared definitions for register_reader: FSM state encoding and index-width helper.
package register_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width needed to hold an index in 0..bit_count inclusive.
   function automatic int idx_width(input int bit_count);
      return $clog2(bit_count + 1);
   endfunction

endpackage

// File: rtl/shift_counter.sv
// Beat counter for register_reader: sync clear, enable-gated increment, terminal flag at LAST.
module shift_counter #(
   parameter int W    = 4,
   parameter int LAST = 7
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  count <= '0;
      else if (clr)  count <= '0;
      else if (en)   count <= count + 1'b1;
   end

   assign tc = (count == W'(LAST));

endmodule

// File: rtl/register_reader.sv
// Snapshots a parallel register word and streams it LSB first with hold/done handshake.
// Optional trailing even-parity beat when REGISTER_READER_PARITY_EN is defined.
module register_reader
   import register_pkg::*;
#(
   parameter int BIT_COUNT = 8
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [BIT_COUNT-1:0]               memory,
   input  logic                               read,
   input  logic                               hold,
   output logic                               read_ready,
   output logic                               serial_out,
   output logic                               bit_valid,
   output logic [idx_width(BIT_COUNT)-1:0]    bit_index,
   output logic                               done
);

   localparam int IW = idx_width(BIT_COUNT);
`ifdef REGISTER_READER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int SW   = BIT_COUNT + PAR;
   localparam int LAST = BIT_COUNT - 1 + PAR;

   state_t          state, state_nxt;
   logic [SW-1:0]   shadow, cap_word;
   logic [IW-1:0]   count;
   logic            tc, accept, adv;

   assign accept = (state == IDLE) && read;
   assign adv    = (state == SHIFT) && !hold;

   // Parity rides in the top shadow bit so it falls out after the data bits.
`ifdef REGISTER_READER_PARITY_EN
   assign cap_word = {^memory, memory};
`else
   assign cap_word = memory;
`endif

   shift_counter #(.W(IW), .LAST(LAST)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (accept),
      .en      (adv),
      .count   (count),
      .tc      (tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    shadow <= '0;
      else if (accept) shadow <= cap_word;
      else if (adv)    shadow <= shadow >> 1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      read_ready = 1'b0;
      serial_out = 1'b0;
      bit_valid  = 1'b0;
      bit_index  = '0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            read_ready = 1'b1;
            if (read) state_nxt = SHIFT;
         end
         SHIFT: begin
            serial_out = shadow[0];
            bit_valid  = 1'b1;
            bit_index  = count;
            if (adv && tc) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_register_reader.sv
// Self-checking bench for register_reader: queue-based reference model, vector table, corner sequences.
module tb_register_reader;

   localparam int BC = 8;
   localparam int IW = $clog2(BC + 1);
`ifdef REGISTER_READER_PARITY_EN
   localparam int NB = BC + 1;
`else
   localparam int NB = BC;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [BC-1:0] memory = '0;
   logic          read = 1'b0;
   logic          hold = 1'b0;
   logic          read_ready, serial_out, bit_valid, done;
   logic [IW-1:0] bit_index;

   register_reader #(.BIT_COUNT(BC)) dut (
      .clk(clk), .reset_n(reset_n), .memory(memory), .read(read), .hold(hold),
      .read_ready(read_ready), .serial_out(serial_out), .bit_valid(bit_valid),
      .bit_index(bit_index), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a read is a list of beats still to be emitted, then one done cycle.
   typedef struct { logic b; int idx; } beat_t;
   beat_t q[$];
   bit    m_done = 0;
   int    dones_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_done = 0;
   endtask

   task automatic model_edge(input logic r, input logic h, input logic [BC-1:0] w);
      beat_t bt;
      if (m_done) m_done = 0;
      else if (q.size() > 0) begin
         if (!h) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1;
         end
      end else if (r) begin
         for (int i = 0; i < BC; i++) begin
            bt.b = w[i]; bt.idx = i; q.push_back(bt);
         end
         if (NB > BC) begin
            bt.b = ($countones(w) % 2 == 1); bt.idx = BC; q.push_back(bt);
         end
      end
   endtask

   task automatic compare_all(input string tag);
      bit v;
      v = (q.size() > 0);
      chk({tag, ".read_ready"}, int'(read_ready), int'(!v && !m_done));
      chk({tag, ".bit_valid"},  int'(bit_valid),  int'(v));
      chk({tag, ".serial_out"}, int'(serial_out), v ? int'(q[0].b) : 0);
      chk({tag, ".bit_index"},  int'(bit_index),  v ? q[0].idx : 0);
      chk({tag, ".done"},       int'(done),       int'(m_done));
      if (done) dones_seen++;
   endtask

   task automatic step(input logic r, input logic h, input string tag);
      read = r; hold = h;
      @(posedge clk);
      model_edge(r, h, memory);
      #1 compare_all(tag);
   endtask

   // One read with an optional stall at a given index; returns captured stream and SHIFT cycle count.
   task automatic run_read(input logic [BC-1:0] w, input logic [BC-1:0] w_after,
                           input int hold_at, input int hold_len, input string tag,
                           output logic [BC:0] col, output int shift_cyc);
      int hl, guard;
      logic h;
      hl = hold_len; col = '0; shift_cyc = 0; guard = 0;
      memory = w;
      step(1'b1, 1'b0, tag);
      memory = w_after;
      while ((q.size() > 0 || m_done) && guard < 200) begin
         h = 1'b0;
         if (q.size() > 0 && q[0].idx == hold_at && hl > 0) begin h = 1'b1; hl--; end
         if (bit_valid) begin
            shift_cyc++;
            if (!h && int'(bit_index) <= BC) col[bit_index] = serial_out;
         end
         step(1'b0, h, tag);
         guard++;
      end
      chk({tag, ".timeout"}, guard >= 200 ? 1 : 0, 0);
   endtask

   typedef struct {
      logic [BC-1:0] mem;
      logic [BC-1:0] mem_after;
      int            hold_at;
      int            hold_len;
      string         name;
   } vec_t;
   vec_t vt[5];

   initial begin
      logic [BC:0] col;
      int          sc, d0;

      vt[0] = '{8'hA5, 8'hA5, -1, 0, "basic_a5"};
      vt[1] = '{8'h3C, 8'hFF,  2, 3, "hold_snap_3c"};
      vt[2] = '{8'h00, 8'hFF,  0, 2, "zero_hold0"};
      vt[3] = '{8'hFF, 8'h00,  7, 1, "ones_holdlast"};
      vt[4] = '{8'h81, 8'h7E, -1, 0, "edges_81"};

      // Reset then idle
      repeat (2) @(posedge clk);
      #1 model_clear(); compare_all("reset");
      @(negedge clk) reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_read(vt[i].mem, vt[i].mem_after, vt[i].hold_at, vt[i].hold_len, vt[i].name, col, sc);
         chk({vt[i].name, ".word"}, int'(col[BC-1:0]), int'(vt[i].mem));
         chk({vt[i].name, ".shift_cycles"}, sc, NB + vt[i].hold_len);
         if (NB > BC) chk({vt[i].name, ".parity"}, int'(col[BC]), $countones(vt[i].mem) % 2);
      end

`ifdef REGISTER_READER_PARITY_EN
      run_read(8'h07, 8'h07, -1, 0, "par_07", col, sc);
      chk("par_07.pbit", int'(col[BC]), 1);
      run_read(8'h03, 8'h03, -1, 0, "par_03", col, sc);
      chk("par_03.pbit", int'(col[BC]), 0);
`endif

      // Busy reads: read held high, exactly one done per NB+2 cycles
      memory = 8'h01;
      d0 = dones_seen;
      for (int i = 0; i < 2 * (NB + 2); i++) step(1'b1, 1'b0, "busy");
      chk("busy.dones", dones_seen - d0, 2);
      step(1'b0, 1'b0, "busy_tail");
      while (q.size() > 0 || m_done) step(1'b0, 1'b0, "busy_drain");

      // Mid-read asynchronous reset at bit_index 4 of F0
      memory = 8'hF0;
      step(1'b1, 1'b0, "midrst");
      while (q.size() > 0 && q[0].idx != 4) step(1'b0, 1'b0, "midrst");
      #2 reset_n = 1'b0;
      #1 model_clear(); compare_all("midrst.async");
      d0 = dones_seen;
      @(posedge clk); #1 compare_all("midrst.held");
      chk("midrst.no_done", dones_seen - d0, 0);
      @(negedge clk) reset_n = 1'b1;
      run_read(8'h0F, 8'h0F, -1, 0, "after_rst", col, sc);
      chk("after_rst.word", int'(col[BC-1:0]), 8'h0F);
      chk("after_rst.shift_cycles", sc, NB);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         memory = BC'($urandom);
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
